uart_tx_arbiter: RTL

- Shares the single UART transmitter between up to NUM_SRC byte-stream requesters (rail sensing, CPU comms, debug/status).
- Arbitration is round-robin at packet granularity; a granted source holds the transmitter until its last byte.
- Sequences the transmitter's start/busy/ready handshake one byte at a time and releases stalled or overlong sources.
- Sits between the requester blocks and the UART transmitter, all on the 100 MHz system clock.

---
 rtl/uart_tx_arbiter_if.sv | 38 +++
 rtl/uart_tx_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the UART transmitter and
// the arbiter that shares it.
//   master : the arbiter side (drives req_ready, uart_start/uart_data, status)
//   slave  : the environment side (requesters + transmitter)
// Signals:
//   req_valid/req_data/req_last  per-source byte stream, source i on data[8i+7:8i]
//   req_ready                    one-cycle byte-accept pulse to the granted source
//   uart_start/uart_data         start pulse and byte to the transmitter
//   uart_busy/uart_ready         transmitter status
//   active/grant_id              grant held / current or last granted source
//   err_timeout/err_overlong     one-cycle abort pulses
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_SRC = 3,
  parameter int unsigned ID_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0]   req_valid;
  logic [8*NUM_SRC-1:0] req_data;
  logic [NUM_SRC-1:0]   req_last;
  logic [NUM_SRC-1:0]   req_ready;
  logic                 uart_start;
  logic [7:0]           uart_data;
  logic                 uart_busy;
  logic                 uart_ready;
  logic                 active;
  logic [ID_W-1:0]      grant_id;
  logic                 err_timeout;
  logic                 err_overlong;

  modport master (
    input  req_valid, req_data, req_last, uart_busy, uart_ready,
    output req_ready, uart_start, uart_data, active, grant_id, err_timeout, err_overlong
  );

  modport slave (
    output req_valid, req_data, req_last, uart_busy, uart_ready,
    input  req_ready, uart_start, uart_data, active, grant_id, err_timeout, err_overlong
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART transmitter between
// NUM_SRC byte-stream requesters. A granted source keeps the transmitter until
// its last byte, a stall (ACK_TIMEOUT cycles) or MAX_PKT_BYTES bytes.
// Ports:
//   sclk  system clock
//   rstn  asynchronous active-low reset
//   bus   uart_tx_arbiter_if.master (requester streams, transmitter handshake, status)
// Optional build macro UART_SRC_TAG_EN: each grant first sends the tag byte
// {4'hA, grant_id} through the normal send path (no req_ready, not counted).
// req_ready and uart_start are decoded from the state so they answer in the same
// cycle; err_timeout/err_overlong are registered and appear in the RELEASE cycle.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC       = 3,
  parameter int unsigned MAX_PKT_BYTES = 64,
  parameter int unsigned ACK_TIMEOUT   = 1024
) (
  input  logic             sclk,
  input  logic             rstn,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned ID_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StSend, StWaitBusy, StWaitDone, StRelease
`ifdef UART_SRC_TAG_EN
    , StTag
`endif
  } state_e;

  state_e             state_q;
  logic [ID_W-1:0]    rr_q;
  logic [ID_W-1:0]    grant_q;
  logic               active_q;
  logic [7:0]         data_q;
  logic               last_q;
  logic [7:0]         count_q;
  logic [TMR_W-1:0]   timer_q;
  logic               err_to_q;
  logic               err_ol_q;
`ifdef UART_SRC_TAG_EN
  logic               tag_q;
`endif

  logic               any_req;
  logic [ID_W-1:0]    winner;
  logic               g_valid;
  logic               g_last;
  logic [7:0]         g_data;
  logic [TMR_W-1:0]   timer_inc;
  logic               timer_hit;
  logic [NUM_SRC-1:0] g_onehot;

  // First requester after the rr pointer, wrapping.
  always_comb begin
    any_req = 1'b0;
    winner  = rr_q;
    for (int unsigned off = 1; off <= NUM_SRC; off++) begin
      int unsigned idx;
      idx = (32'(rr_q) + off) % NUM_SRC;
      if (!any_req && bus.req_valid[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    g_valid  = bus.req_valid[grant_q];
    g_last   = bus.req_last[grant_q];
    g_data   = bus.req_data[{grant_q, 3'b000} +: 8];
    g_onehot = '0;
    g_onehot[grant_q] = 1'b1;
    // Saturating increment; timer_hit marks the cycle the limit is reached.
    timer_inc = (timer_q == TMR_W'(ACK_TIMEOUT)) ? timer_q : timer_q + TMR_W'(1);
    timer_hit = (timer_inc == TMR_W'(ACK_TIMEOUT));
  end

  assign bus.req_ready    = (state_q == StFetch && g_valid) ? g_onehot : '0;
  assign bus.uart_start   = (state_q == StSend) && bus.uart_ready;
  assign bus.uart_data    = data_q;
  assign bus.active       = active_q;
  assign bus.grant_id     = grant_q;
  assign bus.err_timeout  = err_to_q;
  assign bus.err_overlong = err_ol_q;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      rr_q     <= ID_W'(NUM_SRC - 1);
      grant_q  <= '0;
      active_q <= 1'b0;
      data_q   <= '0;
      last_q   <= 1'b0;
      count_q  <= '0;
      timer_q  <= '0;
      err_to_q <= 1'b0;
      err_ol_q <= 1'b0;
`ifdef UART_SRC_TAG_EN
      tag_q    <= 1'b0;
`endif
    end else begin
      err_to_q <= 1'b0;
      err_ol_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            grant_q  <= winner;
            active_q <= 1'b1;
            count_q  <= '0;
            timer_q  <= '0;
`ifdef UART_SRC_TAG_EN
            state_q  <= StTag;
`else
            state_q  <= StFetch;
`endif
          end
        end
`ifdef UART_SRC_TAG_EN
        StTag: begin
          data_q  <= {4'hA, 4'(grant_q)};
          last_q  <= 1'b0;
          tag_q   <= 1'b1;
          timer_q <= '0;
          state_q <= StSend;
        end
`endif
        StFetch: begin
          if (g_valid) begin
            data_q  <= g_data;
            last_q  <= g_last;
`ifdef UART_SRC_TAG_EN
            tag_q   <= 1'b0;
`endif
            timer_q <= '0;
            state_q <= StSend;
          end else if (timer_hit) begin
            err_to_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= StRelease;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StSend: begin
          if (bus.uart_ready) begin
`ifdef UART_SRC_TAG_EN
            if (!tag_q) count_q <= count_q + 8'd1;
`else
            count_q <= count_q + 8'd1;
`endif
            timer_q <= '0;
            state_q <= StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (bus.uart_busy) begin
            timer_q <= '0;
            state_q <= StWaitDone;
          end else if (timer_hit) begin
            err_to_q <= 1'b1;
            timer_q  <= '0;
            state_q  <= StRelease;
          end else begin
            timer_q <= timer_inc;
          end
        end
        StWaitDone: begin
          if (!bus.uart_busy && bus.uart_ready) begin
            timer_q <= '0;
            // last wins over the byte limit; a tag byte never has count at the limit.
            if (last_q) begin
              state_q <= StRelease;
            end else if (count_q == 8'(MAX_PKT_BYTES)) begin
              err_ol_q <= 1'b1;
              state_q  <= StRelease;
            end else begin
              state_q <= StFetch;
            end
          end
        end
        StRelease: begin
          rr_q     <= grant_q;
          active_q <= 1'b0;
          timer_q  <= '0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule
